// File: rtl/vz_saver.sv
// VZ snapshot generator for the ioctl upload channel: header bytes followed by the
// program body, which is read from RAM through a shared one-cycle pulse-read port.
module vz_saver #(
  parameter logic [127:0] NAME_STR = "MISTER"
) (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [15:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [16:0] upload_size,
  input  logic        mode_mcode,
  input  logic [15:0] mc_start,
  input  logic [15:0] mc_end,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        led
);

  // Right-justified string parameter re-packed so that name byte k sits at [8*k +: 8].
  function automatic logic [135:0] pack_name(input logic [127:0] s);
    logic [135:0] r;
    int unsigned  n;
    r = '0;
    n = 0;
    for (int unsigned i = 0; i < 16; i++)
      if (s[8*i +: 8] != 8'h00) n = i + 1;
    for (int unsigned i = 0; i < 16; i++)
      if (i < n) r[8*i +: 8] = s[8*(n-1-i) +: 8];
    return r;
  endfunction

  function automatic logic [16:0] size_of(input logic [15:0] s, input logic [15:0] e);
    return (e >= s) ? 17'd24 + {1'b0, e - s} : 17'd24;
  endfunction

  localparam logic [135:0] NAME_BYTES = pack_name(NAME_STR);

  typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;

  state_t      state, state_d;
  logic        upload_q;
  logic        mcode, mcode_d;
  logic [15:0] start, start_d, stop, stop_d;
  logic [2:0]  step, step_d;
  logic        pend1, pend1_d, pend2, pend2_d;
  logic        body, body_d;
  logic [7:0]  hdr, hdr_d, hdr_sel, din_d;
  logic        wait_d, rd_d, led_d;
  logic [15:0] addr_d;
  logic [16:0] size_d;

  always_comb begin
    hdr_sel = 8'h00;
    case (ioctl_addr[4:0])
      5'd0:    hdr_sel = 8'h56;
      5'd1:    hdr_sel = 8'h5A;
      5'd2:    hdr_sel = 8'h46;
      5'd3:    hdr_sel = 8'h30;
      5'd21:   hdr_sel = mcode ? 8'hF1 : 8'hF0;
      5'd22:   hdr_sel = start[7:0];
      5'd23:   hdr_sel = start[15:8];
      default: if (ioctl_addr[4:0] >= 5'd4 && ioctl_addr[4:0] <= 5'd20)
                 hdr_sel = NAME_BYTES[8*(ioctl_addr[4:0] - 5'd4) +: 8];
    endcase
  end

  always_comb begin
    state_d = state;
    mcode_d = mcode;
    start_d = start;
    stop_d  = stop;
    step_d  = step;
    pend1_d = 1'b0;
    pend2_d = pend1;
    body_d  = body;
    hdr_d   = hdr;
    din_d   = ioctl_din;
    wait_d  = ioctl_wait;
    rd_d    = 1'b0;
    addr_d  = mem_addr;
    size_d  = upload_size;
    led_d   = ioctl_upload;

    if (!ioctl_upload && upload_q) begin
      state_d = IDLE;
      wait_d  = 1'b0;
      pend2_d = 1'b0;
      step_d  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ioctl_upload && !upload_q) begin
            mcode_d = mode_mcode;
            wait_d  = 1'b1;
            if (mode_mcode) begin
              start_d = mc_start;
              stop_d  = mc_end;
              size_d  = size_of(mc_start, mc_end);
              state_d = READY;
            end else begin
              rd_d    = 1'b1;
              addr_d  = 16'h78A4;
              step_d  = '0;
              state_d = FETCH;
            end
          end
        end
        FETCH: begin
          // Odd steps capture the byte requested two cycles earlier and issue the next read.
          step_d = step + 3'd1;
          if (step[0]) begin
            case (step[2:1])
              2'd0: begin start_d[7:0]  = mem_data; rd_d = 1'b1; addr_d = 16'h78A5; end
              2'd1: begin start_d[15:8] = mem_data; rd_d = 1'b1; addr_d = 16'h78F9; end
              2'd2: begin stop_d[7:0]   = mem_data; rd_d = 1'b1; addr_d = 16'h78FA; end
              default: begin
                stop_d[15:8] = mem_data;
                size_d       = size_of(start, {mem_data, stop[7:0]});
                wait_d       = 1'b0;
                state_d      = READY;
              end
            endcase
          end
        end
        READY: begin
          wait_d = 1'b0;
          if (pend2) din_d = body ? mem_data : hdr;
          if (ioctl_rd && !pend1 && !pend2) begin
            pend1_d = 1'b1;
            if (ioctl_addr < 16'd24) begin
              body_d = 1'b0;
              hdr_d  = hdr_sel;
            end else if ({1'b0, ioctl_addr} < upload_size) begin
              body_d = 1'b1;
              rd_d   = 1'b1;
              addr_d = start + (ioctl_addr - 16'd24);
            end else begin
              body_d = 1'b0;
              hdr_d  = 8'h00;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Tracks the upload level through reset so a transfer held high across reset does not restart.
  always_ff @(posedge I_CLK) upload_q <= ioctl_upload;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state       <= IDLE;
      mcode       <= 1'b0;
      start       <= '0;
      stop        <= '0;
      step        <= '0;
      pend1       <= 1'b0;
      pend2       <= 1'b0;
      body        <= 1'b0;
      hdr         <= '0;
      ioctl_din   <= '0;
      ioctl_wait  <= 1'b0;
      upload_size <= '0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      led         <= 1'b0;
    end else begin
      state       <= state_d;
      mcode       <= mcode_d;
      start       <= start_d;
      stop        <= stop_d;
      step        <= step_d;
      pend1       <= pend1_d;
      pend2       <= pend2_d;
      body        <= body_d;
      hdr         <= hdr_d;
      ioctl_din   <= din_d;
      ioctl_wait  <= wait_d;
      upload_size <= size_d;
      mem_addr    <= addr_d;
      mem_rd      <= rd_d;
      led         <= led_d;
    end
  end

endmodule

// File: tb/tb_vz_saver.sv
// Bench for vz_saver: RAM model, VZ file reference model and a scoreboard-driven read monitor.
module tb_vz_saver;

  logic        clk = 1'b0;
  logic        rst;
  logic        ioctl_upload, ioctl_rd;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [16:0] upload_size;
  logic        mode_mcode;
  logic [15:0] mc_start, mc_end;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        led;

  always #5 clk = ~clk;

  vz_saver #(.NAME_STR("MISTER")) dut (
    .I_CLK(clk), .I_RST(rst),
    .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .upload_size(upload_size),
    .mode_mcode(mode_mcode), .mc_start(mc_start), .mc_end(mc_end),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .led(led)
  );

  logic [7:0] ram [0:65535];
  always @(posedge clk) if (mem_rd === 1'b1) mem_data <= ram[mem_addr];

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference model of the file being served.
  logic [15:0] m_start, m_end;
  bit          m_mcode;
  int          m_size;
  logic [7:0]  hdr_bytes [0:23];

  function automatic void build_model();
    string nm = "MISTER";
    m_size = (m_end >= m_start) ? 24 + int'(m_end) - int'(m_start) : 24;
    hdr_bytes[0] = "V"; hdr_bytes[1] = "Z"; hdr_bytes[2] = "F"; hdr_bytes[3] = "0";
    for (int i = 0; i < 17; i++) hdr_bytes[4+i] = (i < nm.len()) ? nm[i] : 8'h00;
    hdr_bytes[21] = m_mcode ? 8'hF1 : 8'hF0;
    hdr_bytes[22] = m_start[7:0];
    hdr_bytes[23] = m_start[15:8];
  endfunction

  typedef struct {
    bit          hold;
    bit          body;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model_read(int a);
    exp_t e;
    e.hold = 0; e.body = 0; e.addr = '0; e.data = 8'h00;
    if (a < 24) e.data = hdr_bytes[a];
    else if (a < m_size) begin
      e.body = 1;
      e.addr = 16'((int'(m_start) + a - 24) % 65536);
      e.data = ram[e.addr];
    end
    return e;
  endfunction

  // Monitor: every strobe the DUT samples is matched against the next scoreboard entry.
  bit         mon_en = 1;
  logic [7:0] din_model = 8'h00;
  exp_t       cur;
  initial begin
    forever begin
      @(posedge clk);
      if (mon_en && ioctl_rd === 1'b1) begin
        if (sb.size() == 0) check("sb_unexpected_strobe", 32'd1, 32'd0);
        else begin
          cur = sb.pop_front();
          @(negedge clk);
          check("mem_rd_on_read", mem_rd, cur.body);
          if (cur.body) check("mem_addr", mem_addr, cur.addr);
          @(negedge clk);
          check("din_before_e2", ioctl_din, din_model);
          @(posedge clk); #1;
          if (!cur.hold) din_model = cur.data;
          check("din", ioctl_din, din_model);
        end
      end
    end
  end

  bit   chk_pulse = 0;
  logic mem_rd_q  = 1'b0;
  always @(negedge clk) begin
    if (chk_pulse) check("mem_rd_back_to_back", mem_rd & mem_rd_q, 1'b0);
    mem_rd_q <= mem_rd;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_read(int a);
    exp_t e = model_read(a);
    @(posedge clk); #2;
    sb.push_back(e);
    ioctl_rd = 1'b1; ioctl_addr = 16'(a);
    @(posedge clk); #2;
    ioctl_rd = 1'b0;
    repeat (1 + $urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(posedge clk); n++; end
    check("sb_drain", sb.size(), 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic start_upload(bit mc, logic [15:0] s, logic [15:0] e, int exp_wait);
    int cnt = 0;
    @(posedge clk); #2;
    mode_mcode = mc; mc_start = s; mc_end = e; ioctl_upload = 1'b1;
    @(posedge clk); #2;
    mode_mcode = ~mc; mc_start = 16'($urandom); mc_end = 16'($urandom);
    if (!mc) begin
      check("fetch_first_rd", mem_rd, 1'b1);
      check("fetch_first_addr", mem_addr, 16'h78A4);
    end
    if (mc) begin m_start = s; m_end = e; end
    else begin
      m_start = {ram[16'h78A5], ram[16'h78A4]};
      m_end   = {ram[16'h78FA], ram[16'h78F9]};
    end
    m_mcode = mc;
    build_model();
    while (ioctl_wait === 1'b1 && cnt < 30) begin cnt++; @(posedge clk); #2; end
    check("wait_len", cnt, exp_wait);
    check("upload_size", upload_size, m_size);
    check("led_on", led, 1'b1);
  endtask

  task automatic stop_upload();
    drain();
    ioctl_upload = 1'b0;
    @(posedge clk); #2;
    check("wait_after_stop", ioctl_wait, 1'b0);
    check("led_after_stop", led, 1'b0);
  endtask

  task automatic read_file(int extra);
    for (int a = 0; a < m_size + 2; a++) do_read(a);
    for (int i = 0; i < extra; i++) do_read($urandom_range(0, m_size + 4));
  endtask

  task automatic set_ptrs(logic [15:0] s, logic [15:0] e);
    ram[16'h78A4] = s[7:0]; ram[16'h78A5] = s[15:8];
    ram[16'h78F9] = e[7:0]; ram[16'h78FA] = e[15:8];
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    rst = 1'b1; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
    mode_mcode = 1'b0; mc_start = '0; mc_end = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_din", ioctl_din, 8'h00);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_size", upload_size, 17'd0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_rd", mem_rd, 1'b0);
    check("rst_led", led, 1'b0);
    rst = 1'b0;
    chk_pulse = 1;

    // BASIC save with the documented program.
    set_ptrs(16'h7AE9, 16'h7AF1);
    for (int i = 0; i < 8; i++) ram[16'h7AE9 + i] = 8'(8'h11 + i);
    start_upload(1'b0, '0, '0, 8);
    check("basic_size", upload_size, 17'd32);
    read_file(6);
    stop_upload();

    // Machine-code save.
    for (int i = 0; i < 4; i++) ram[16'h8000 + i] = 8'(8'hA0 + i);
    start_upload(1'b1, 16'h8000, 16'h8004, 1);
    check("mc_size", upload_size, 17'd28);
    read_file(4);
    stop_upload();

    // Inverted range via BASIC pointers: empty body.
    set_ptrs(16'h7AE9, 16'h7000);
    start_upload(1'b0, '0, '0, 8);
    check("inv_size", upload_size, 17'd24);
    do_read(24); do_read(25); do_read(22); do_read(23);
    stop_upload();

    // Wrapped range counts as inverted; a one-byte body at the top of memory.
    start_upload(1'b1, 16'hFFFE, 16'h0001, 1);
    check("wrap_size", upload_size, 17'd24);
    do_read(24); do_read(21);
    stop_upload();
    start_upload(1'b1, 16'hFFFE, 16'hFFFF, 1);
    do_read(24); do_read(25);
    stop_upload();

    // Randomised machine-code ranges.
    for (int r = 0; r < 5; r++) begin
      logic [15:0] s;
      s = 16'($urandom);
      start_upload(1'b1, s, s + 16'($urandom_range(0, 12)), 1);
      read_file(3);
      stop_upload();
    end

    // Abort during FETCH, then check silence and IDLE behaviour.
    set_ptrs(16'h6000, 16'h6005);
    @(posedge clk); #2;
    mode_mcode = 1'b0; ioctl_upload = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    ioctl_upload = 1'b0;
    @(posedge clk); #2;
    check("abort_wait", ioctl_wait, 1'b0);
    check("abort_led", led, 1'b0);
    check("abort_rd", mem_rd, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      check("abort_no_rd", mem_rd, 1'b0);
    end
    begin
      exp_t h;
      h.hold = 1; h.body = 0; h.addr = '0; h.data = 8'h00;
      @(posedge clk); #2;
      sb.push_back(h);
      ioctl_rd = 1'b1; ioctl_addr = 16'd30;
      @(posedge clk); #2;
      ioctl_rd = 1'b0;
      drain();
    end
    start_upload(1'b0, '0, '0, 8);
    do_read(22); do_read(24); do_read(28);
    stop_upload();

    // Read latency on a body byte, then reset in the middle of a read.
    start_upload(1'b1, 16'h9000, 16'h9010, 1);
    do_read(30);
    drain();
    mon_en = 0;
    ioctl_rd = 1'b1; ioctl_addr = 16'd31;
    @(posedge clk); #2;
    ioctl_rd = 1'b0;
    check("rst_mid_rd_issued", mem_rd, 1'b1);
    rst = 1'b1;
    @(posedge clk); #2;
    check("rst_mid_din", ioctl_din, 8'h00);
    check("rst_mid_wait", ioctl_wait, 1'b0);
    check("rst_mid_size", upload_size, 17'd0);
    check("rst_mid_addr", mem_addr, 16'h0000);
    check("rst_mid_rd", mem_rd, 1'b0);
    check("rst_mid_led", led, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("no_restart_wait", ioctl_wait, 1'b0);
      check("no_restart_size", upload_size, 17'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vz_saver.md
# vz_saver

Produces a `.vz` snapshot file for upload to the host over the MiSTer ioctl upload channel, so a program in Laser310 RAM can be saved to SD. It is the inverse of the program loader. On upload start it reads the program's start and end addresses from RAM, then answers host byte reads with a 24-byte VZ header followed by the program body. It shares the CPU-side RAM read port through a simple pulse-read interface.

## Interface
Parameters:
- `NAME_STR`, default `"MISTER"`: program name placed in header bytes 4..20. Up to 16 ASCII characters, zero-padded; byte 20 is always 0x00.

Ports:
- `I_CLK`, in, 1: system clock.
- `I_RST`, in, 1: reset, synchronous, active-high.
- `ioctl_upload`, in, 1: high for the whole upload transfer.
- `ioctl_rd`, in, 1: one-cycle host byte read strobe.
- `ioctl_addr`, in, 16: file byte offset for the read.
- `ioctl_din`, out, 8: file byte returned to the host.
- `ioctl_wait`, out, 1: host must stall reads while this is high.
- `upload_size`, out, 17: total file length in bytes.
- `mode_mcode`, in, 1: 0 selects BASIC (type 0xF0); 1 selects machine code (type 0xF1).
- `mc_start`, in, 16: machine-code start address, used when `mode_mcode`=1.
- `mc_end`, in, 16: machine-code end address (exclusive), used when `mode_mcode`=1.
- `mem_addr`, out, 16: RAM read address.
- `mem_rd`, out, 1: one-cycle RAM read strobe.
- `mem_data`, in, 8: RAM read data, valid exactly 1 cycle after `mem_rd`.
- `led`, out, 1: high while `ioctl_upload` is high.

## Operation
States: IDLE, FETCH, READY.

- **IDLE**
  - On a rising edge of `ioctl_upload`, `mode_mcode` and `mc_start`/`mc_end` are latched.
  - BASIC mode enters FETCH.
  - Machine-code mode sets start=`mc_start`, end=`mc_end` and goes to READY.
- **FETCH** (BASIC only)
  - Four sequential RAM reads: 0x78A4 → start[7:0], 0x78A5 → start[15:8], 0x78F9 → end[7:0], 0x78FA → end[15:8].
  - Each read issues `mem_rd` for one cycle and captures `mem_data` on the next cycle. Read n+1 issues on the cycle after read n is captured.
  - `ioctl_wait`=1 throughout FETCH, then → READY.
- **READY**: serves `ioctl_rd` requests.
  - Header offsets 0..3: 0x56 0x5A 0x46 0x30 ("VZF0").
  - Header offsets 4..20: name.
  - Header offset 21: 0xF0 or 0xF1.
  - Header offset 22: start[7:0]; offset 23: start[15:8].
  - Offset a ≥ 24 with a < `upload_size`: issue `mem_rd` with `mem_addr` = start + (a − 24), modulo 2^16; return `mem_data`.
  - Offset a ≥ `upload_size`: return 0x00 with no `mem_rd`.
- `upload_size` = 24 + (end − start) when end ≥ start; otherwise 24, with no body. Computed in 17 bits and held stable in READY.
- A falling edge of `ioctl_upload` in any state → IDLE. Any in-flight read is abandoned and `ioctl_wait`=0.
- In FETCH, `ioctl_rd` is ignored.
- In IDLE, `ioctl_rd` is ignored and `ioctl_din` holds its value.

## Timing
- **Reset values**: state IDLE; `ioctl_din`=0, `ioctl_wait`=0, `upload_size`=0, `mem_addr`=0, `mem_rd`=0, `led`=0.
- **Reset mid-transfer**: the block returns to IDLE. The upload restarts only on a new rising edge of `ioctl_upload`.
- **Upload start**: `ioctl_wait` rises the cycle after `ioctl_upload` is first sampled high.
  - BASIC: `ioctl_wait` stays high exactly 8 cycles.
  - Machine code: `ioctl_wait` stays high 1 cycle.
- **Read latency**: `ioctl_rd` is sampled at edge E0; `ioctl_din` is updated at E0+2 for both header and body bytes.
  - For body bytes, `mem_rd`/`mem_addr` are registered at E0 and `mem_data` is captured at E0+1.
  - `ioctl_din` holds its value until the next update.
- **Read spacing**: the host spaces `ioctl_rd` at least 3 cycles apart. A strobe arriving while a read is pending is dropped.
- `mem_rd` is never high for two consecutive cycles.

## Test plan
- **BASIC save**: RAM[0x78A4..5]=0x7AE9, RAM[0x78F9..A]=0x7AF1, body bytes 0x11..0x18, `mode_mcode`=0.
  - Required: `ioctl_wait` high 8 cycles; `upload_size`=32.
  - Offsets 0..3 read "VZF0"; offset 21 = 0xF0; offsets 22/23 = 0xE9/0x7A.
  - Offsets 24..31 return 0x11..0x18, with `mem_addr` 0x7AE9..0x7AF0.
- **Machine-code save**: `mc_start`=0x8000, `mc_end`=0x8004.
  - Required: `upload_size`=28; offset 21 = 0xF1; offsets 22/23 = 0x00/0x80.
  - Offsets 24..27 are read from 0x8000..0x8003.
- **Empty/inverted range**: end=0x7000, start=0x7AE9.
  - Required: `upload_size`=24; offset 24 returns 0x00 with no `mem_rd`.
- **Address wrap**: `mc_start`=0xFFFE, `mc_end`=0x0001.
  - Required: `upload_size`=24, per the inverted-range rule.
  - Separately, with start=0xFFFE, end=0xFFFF: offset 24 reads 0xFFFE.
- **Abort**: drop `ioctl_upload` during FETCH (cycle 4).
  - Required: `ioctl_wait`=0 next cycle, no further `mem_rd`, `led`=0, state IDLE.
  - Re-raising `ioctl_upload` restarts FETCH at 0x78A4.
- **Latency/reset**: `ioctl_rd` at offset 30.
  - Required: `mem_rd` one cycle after the strobe; `ioctl_din` valid at E0+2.
  - Asserting `I_RST` mid-read clears all outputs to their reset values on the next edge.
